// File: rtl/keypad_scanner_hist.sv
// Matrix keypad scanner: one-cold column drive, synchronised active-low rows, press/release
// debounce, multi-key rejection and a DEPTH-entry shift register of captured key codes.
module keypad_scanner_hist #(
   parameter int  NUM_ROWS        = 4,
   parameter int  NUM_COLS        = 4,
   parameter int  SCAN_DWELL      = 4,
   parameter int  DEBOUNCE_CYCLES = 128,
   parameter int  DEPTH           = 2,
   localparam int KW              = $clog2(NUM_ROWS * NUM_COLS)
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [NUM_ROWS-1:0] Rows,
   input  logic                Clear,
   output logic [NUM_COLS-1:0] Cols,
   output logic [DEPTH*KW-1:0] Keys,
   output logic                KeyValid,
   output logic                KeyErr,
   output logic                KeyDown
);

   localparam int MAXC = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam int CIW  = $clog2(NUM_COLS);
   localparam int RIW  = $clog2(NUM_ROWS);
   localparam int LCW  = $clog2(NUM_ROWS + 1);

   localparam logic [2:0] ST_SCAN     = 3'd0;
   localparam logic [2:0] ST_DEBOUNCE = 3'd1;
   localparam logic [2:0] ST_CAPTURE  = 3'd2;
   localparam logic [2:0] ST_HOLD     = 3'd3;
   localparam logic [2:0] ST_RELEASE  = 3'd4;

   localparam logic [CW-1:0]  DWELL_LAST = CW'(SCAN_DWELL - 1);
   localparam logic [CW-1:0]  DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CIW-1:0] COL_LAST   = CIW'(NUM_COLS - 1);

   logic [NUM_ROWS-1:0] row_s1_q, row_s1_d;
   logic [NUM_ROWS-1:0] row_s2_q, row_s2_d;
   logic [2:0]          state_q, state_d;
   logic [CIW-1:0]      col_q, col_d;
   logic [NUM_COLS-1:0] cols_q, cols_d;
   logic [CW-1:0]       dwell_q, dwell_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DEPTH*KW-1:0] keys_q, keys_d;
   logic                key_valid_q, key_valid_d;
   logic                key_err_q, key_err_d;
   logic                key_down_q, key_down_d;

   logic                pressed_s;
   logic                onehot_s;
   logic                shift_s;
   logic [LCW-1:0]      low_cnt_s;
   logic [RIW-1:0]      row_idx_s;
   logic [KW-1:0]       code_s;
   logic [CIW-1:0]      col_next_s;

   assign row_s1_d = Rows;
   assign row_s2_d = row_s1_q;

   // Count low rows and remember which one; only meaningful when exactly one is low.
   always_comb begin
      low_cnt_s = {LCW{1'b0}};
      row_idx_s = {RIW{1'b0}};
      for (int r = 0; r < NUM_ROWS; r++) begin
         low_cnt_s = low_cnt_s + (row_s2_q[r] ? LCW'(0) : LCW'(1));
         row_idx_s = row_s2_q[r] ? row_idx_s : RIW'(r);
      end
   end

   assign pressed_s  = ~&row_s2_q;
   assign onehot_s   = (low_cnt_s == LCW'(1));
   assign code_s     = KW'(int'(row_idx_s) * NUM_COLS + int'(col_q));
   assign col_next_s = (col_q == COL_LAST) ? {CIW{1'b0}} : col_q + CIW'(1);

   // Scan / debounce / capture / hold / release sequencing.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      dwell_d     = dwell_q;
      cnt_d       = cnt_q;
      key_valid_d = 1'b0;
      key_err_d   = 1'b0;
      shift_s     = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = {CW{1'b0}};
               if (pressed_s) begin
                  state_d = ST_DEBOUNCE;
                  cnt_d   = {CW{1'b0}};
               end else begin
                  col_d   = col_next_s;
               end
            end else begin
               dwell_d = dwell_q + CW'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (!pressed_s) begin
               state_d = ST_SCAN;
               dwell_d = {CW{1'b0}};
               cnt_d   = {CW{1'b0}};
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_CAPTURE;
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         ST_CAPTURE: begin
            state_d = ST_HOLD;
            if (onehot_s) begin
               shift_s     = 1'b1;
               key_valid_d = 1'b1;
            end else begin
               key_err_d   = 1'b1;
            end
         end
         ST_HOLD: begin
            if (!pressed_s) begin
               state_d = ST_RELEASE;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_RELEASE: begin
            if (pressed_s) begin
               state_d = ST_HOLD;
               cnt_d   = {CW{1'b0}};
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_SCAN;
               col_d   = col_next_s;
               dwell_d = {CW{1'b0}};
               cnt_d   = {CW{1'b0}};
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            // Corrupted state: restart scanning but keep the history.
            state_d = ST_SCAN;
            col_d   = {CIW{1'b0}};
            dwell_d = {CW{1'b0}};
            cnt_d   = {CW{1'b0}};
         end
      endcase
      key_down_d = (state_d == ST_CAPTURE) || (state_d == ST_HOLD) || (state_d == ST_RELEASE);
   end

   // One-cold column pattern registered alongside the column index.
   always_comb begin
      cols_d = {NUM_COLS{1'b1}};
      for (int c = 0; c < NUM_COLS; c++) begin
         cols_d[c] = (col_d != CIW'(c));
      end
   end

   // History shift; Clear empties older entries even when a code is shifted in.
   always_comb begin
      keys_d = keys_q;
      if (shift_s) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            keys_d[i*KW +: KW] = Clear ? {KW{1'b0}} : keys_q[(i-1)*KW +: KW];
         end
         keys_d[KW-1:0] = code_s;
      end else if (Clear) begin
         keys_d = {(DEPTH*KW){1'b0}};
      end else begin
         keys_d = keys_q;
      end
   end

   // Row synchroniser flops, reset to the idle (all high) level.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         row_s1_q <= {NUM_ROWS{1'b1}};
         row_s2_q <= {NUM_ROWS{1'b1}};
      end else begin
         row_s1_q <= row_s1_d;
         row_s2_q <= row_s2_d;
      end
   end

   // Control state, counters, history and registered outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= ST_SCAN;
         col_q       <= {CIW{1'b0}};
         cols_q      <= {{(NUM_COLS-1){1'b1}}, 1'b0};
         dwell_q     <= {CW{1'b0}};
         cnt_q       <= {CW{1'b0}};
         keys_q      <= {(DEPTH*KW){1'b0}};
         key_valid_q <= 1'b0;
         key_err_q   <= 1'b0;
         key_down_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         cols_q      <= cols_d;
         dwell_q     <= dwell_d;
         cnt_q       <= cnt_d;
         keys_q      <= keys_d;
         key_valid_q <= key_valid_d;
         key_err_q   <= key_err_d;
         key_down_q  <= key_down_d;
      end
   end

   assign Cols     = cols_q;
   assign Keys     = keys_q;
   assign KeyValid = key_valid_q;
   assign KeyErr   = key_err_q;
   assign KeyDown  = key_down_q;

endmodule
